// File: rtl/calc_sequencer.sv
// calc_sequencer: calculator entry FSM gating BCD operand registers and sequencing the ALU
module calc_sequencer #(
  parameter int DIGITS  = 3,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic       Clock_10ms,
  input  logic       reset,
  input  logic [3:0] digit,
  input  logic       validHigh,
  input  logic       backspace,
  input  logic       negative,
  input  logic       alu_done,
  input  logic       alu_overflow,
  output logic [1:0] enA,
  output logic [1:0] enB,
  output logic [1:0] opCode,
  output logic       alu_start,
  output logic       clear_regs,
  output logic       load_result,
  output logic       resultValid,
  output logic       error,
  output logic [2:0] state
);
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] MAXC = CW'(DIGITS);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    COMPUTE = 3'd2,
    SHOW    = 3'd3,
    ERROR   = 3'd4
  } state_t;
  state_t cur, nxt;
  logic [CW-1:0] cnt_a, cnt_b, cnt_a_n, cnt_b_n;
  logic [TW-1:0] timer, timer_n;
  logic [1:0] op_n, key_op;
  logic start_n, clr_n, load_n;
  logic key, is_clear, is_digit, is_op, is_eq, do_bs;
  logic unused_negative;
  assign unused_negative = negative;
  assign key      = validHigh && digit != 4'd15;
  assign is_clear = key && digit == 4'd14;
  assign is_digit = key && digit <= 4'd9;
  assign is_op    = key && digit >= 4'd10 && digit <= 4'd12;
  assign is_eq    = key && digit == 4'd13;
  assign do_bs    = backspace && !key;
  assign key_op   = 2'(digit - 4'd10);
  assign enA = {cur == ENTER_A && cnt_a < MAXC, cur == ENTER_A};
  assign enB = {cur == ENTER_B && cnt_b < MAXC, cur == ENTER_B};
  assign resultValid = cur == SHOW;
  assign error = cur == ERROR;
  assign state = cur;
  // state, counters, operator latch, timer and registered pulses
  always_ff @(posedge Clock_10ms or negedge reset) begin
    if (!reset) begin
      cur         <= ENTER_A;
      cnt_a       <= '0;
      cnt_b       <= '0;
      opCode      <= 2'b00;
      timer       <= '0;
      alu_start   <= 1'b0;
      clear_regs  <= 1'b0;
      load_result <= 1'b0;
    end else begin
      cur         <= nxt;
      cnt_a       <= cnt_a_n;
      cnt_b       <= cnt_b_n;
      opCode      <= op_n;
      timer       <= timer_n;
      alu_start   <= start_n;
      clear_regs  <= clr_n;
      load_result <= load_n;
    end
  end
  // next-state decode: clear key overrides everything, then per-state key handling
  always_comb begin
    nxt     = cur;
    cnt_a_n = cnt_a;
    cnt_b_n = cnt_b;
    op_n    = opCode;
    timer_n = timer;
    start_n = 1'b0;
    clr_n   = 1'b0;
    load_n  = 1'b0;
    if (is_clear) begin
      nxt     = ENTER_A;
      cnt_a_n = '0;
      cnt_b_n = '0;
      op_n    = 2'b00;
      timer_n = '0;
      clr_n   = 1'b1;
    end else begin
      case (cur)
        ENTER_A: begin
          if (is_digit && cnt_a < MAXC) cnt_a_n = cnt_a + CW'(1);
          else if (is_op && cnt_a != '0) begin
            op_n    = key_op;
            cnt_b_n = '0;
            nxt     = ENTER_B;
          end else if (do_bs && cnt_a != '0) cnt_a_n = cnt_a - CW'(1);
        end
        ENTER_B: begin
          if (is_digit && cnt_b < MAXC) cnt_b_n = cnt_b + CW'(1);
          else if (is_op && cnt_b == '0) op_n = key_op;
          else if (is_eq && cnt_b != '0) begin
            start_n = 1'b1;
            timer_n = '0;
            nxt     = COMPUTE;
          end else if (do_bs) begin
            if (cnt_b != '0) cnt_b_n = cnt_b - CW'(1);
            else nxt = ENTER_A;
          end
        end
        COMPUTE: begin
          timer_n = timer + TW'(1);
          if (alu_done) nxt = alu_overflow ? ERROR : SHOW;
          else if (timer == TMAX) nxt = ERROR;
        end
        SHOW: begin
          if (is_digit) begin
            clr_n   = 1'b1;
            cnt_a_n = '0;
            cnt_b_n = '0;
            nxt     = ENTER_A;
          end else if (is_op) begin
            load_n  = 1'b1;
            cnt_a_n = MAXC;
            cnt_b_n = '0;
            op_n    = key_op;
            nxt     = ENTER_B;
          end
        end
        default: nxt = cur;
      endcase
    end
  end
endmodule
